// File: rtl/pim_mem_pkg.sv
// Shared types for the PIM data-memory path: RAM ownership encoding
// and default arbitration limits, also used by the PIM DMA controller.
package pim_mem_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_PIM = 1'b1
   } own_t;

   localparam int STARVE_MAX_DEF = 8;
   localparam int BURST_MAX_DEF  = 16;

endpackage

// File: rtl/pim_dmem_arbiter.sv
// Data-RAM arbiter between the darkriscv data port (C_*) and the PIM DMA
// requester (P_*); drives the single-port RAM (M_*), stalls CPU via C_HLT.
// Ports: CLK/RES clock and sync reset; C_* CPU side; P_* PIM side; M_* RAM.
module pim_dmem_arbiter
   import pim_mem_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int BURST_MAX  = BURST_MAX_DEF
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic [31:0] C_DADDR,
   input  logic [31:0] C_DATAO,
   input  logic [3:0]  C_BE,
   input  logic        C_WR,
   input  logic        C_RD,
   output logic [31:0] C_DATAI,
   output logic        C_HLT,
   input  logic        P_REQ,
   input  logic        P_WR,
   input  logic [31:0] P_ADDR,
   input  logic [31:0] P_WDATA,
   input  logic [3:0]  P_BE,
   input  logic        P_LAST,
   output logic        P_GNT,
   output logic        P_RVALID,
   output logic [31:0] P_RDATA,
   output logic [31:0] M_A,
   output logic [31:0] M_D,
   output logic [3:0]  M_BE,
   output logic        M_WE,
   input  logic [31:0] M_Q
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int BW = $clog2(BURST_MAX + 1);

   own_t        state;
   logic [SW-1:0] starve_cnt;
   logic [BW-1:0] beat_cnt;
   logic [BW-1:0] beat_nxt;
   logic        cpu_rd_d;
   logic        pim_rd_d;
   logic [31:0] hold;

   logic        cpu_acc;
   logic        pim_sel;
   logic        gnt;
   logic        hlt;
   logic        we;
   logic        cpu_issue;
   logic        pim_done;

   assign cpu_acc = C_WR | C_RD;

   // Saturates so an uncapped burst (CPU idle) cannot wrap the counter.
   assign beat_nxt = (beat_cnt == BW'(BURST_MAX)) ? beat_cnt
                                                 : beat_cnt + 1'b1;

   always_comb begin
      pim_sel = 1'b0;
      gnt     = 1'b0;
      hlt     = 1'b0;
      unique case (state)
         OWN_CPU: begin
            if (!cpu_acc && P_REQ) begin
               pim_sel = 1'b1;
               gnt     = 1'b1;
            end
         end
         OWN_PIM: begin
            pim_sel = 1'b1;
            gnt     = P_REQ;
            hlt     = 1'b1;
         end
         default: ;
      endcase
      if (RES) begin
         gnt = 1'b0;
         hlt = 1'b0;
      end
   end

   always_comb begin
      if (pim_sel) begin
         M_A  = P_ADDR;
         M_D  = P_WDATA;
         M_BE = P_BE;
         we   = gnt & P_WR;
      end else begin
         M_A  = C_DADDR;
         M_D  = C_DATAO;
         M_BE = C_BE;
         we   = C_WR;
      end
      if (RES)
         we = 1'b0;
   end

   assign cpu_issue = (state == OWN_CPU) & C_RD;

   // Burst ends on last beat, a request bubble, or the cap while CPU waits.
   assign pim_done = !P_REQ || P_LAST ||
                     (cpu_acc && beat_nxt == BW'(BURST_MAX));

   always_ff @(posedge CLK) begin
      if (RES) begin
         state      <= OWN_CPU;
         starve_cnt <= '0;
         beat_cnt   <= '0;
         cpu_rd_d   <= 1'b0;
         pim_rd_d   <= 1'b0;
         hold       <= '0;
      end else begin
         cpu_rd_d <= cpu_issue;
         pim_rd_d <= gnt & ~P_WR;
         if (cpu_rd_d)
            hold <= M_Q;
         unique case (state)
            OWN_CPU: begin
               if (cpu_acc) begin
                  if (P_REQ) begin
                     if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                        state      <= OWN_PIM;
                        starve_cnt <= '0;
                        beat_cnt   <= '0;
                     end else begin
                        starve_cnt <= starve_cnt + 1'b1;
                     end
                  end else begin
                     starve_cnt <= '0;
                  end
               end else begin
                  starve_cnt <= '0;
                  if (P_REQ && !P_LAST) begin
                     state    <= OWN_PIM;
                     beat_cnt <= BW'(1);
                  end
               end
            end
            OWN_PIM: begin
               if (pim_done) begin
                  state    <= OWN_CPU;
                  beat_cnt <= '0;
               end else begin
                  beat_cnt <= beat_nxt;
               end
            end
            default: state <= OWN_CPU;
         endcase
      end
   end

   assign P_GNT    = gnt;
   assign C_HLT    = hlt;
   assign M_WE     = we;
   assign P_RVALID = pim_rd_d;
   assign P_RDATA  = M_Q;
   // A read issued just before a stall stays visible for the whole stall.
   assign C_DATAI  = cpu_rd_d ? M_Q : hold;

endmodule
